// File: rtl/sd_sector_buffer.sv
// Sector capture buffer: stores one sector streamed from the SD reader,
// tracks fill count, running checksum and sticky status flags, and serves random-access reads.
module sd_sector_buffer #(
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_W       = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              rd_busy,
    input  logic              rd_error,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_data_valid,
    output logic              sector_ready,
    output logic [ADDR_W:0]   byte_count,
    output logic [15:0]       checksum,
    output logic              short_sector,
    output logic              error_flag,
    output logic              overrun,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(SECTOR_BYTES - 1);

    state_t     state;
    logic [7:0] mem [SECTOR_BYTES];
    logic       rd_busy_q;
    logic       capturing;
    logic       wr_en;
    logic       last_byte;
    logic       busy_fall;

    // Handshakes: in_valid is a one-cycle strobe with no backpressure (bytes not
    // accepted are dropped); rd_en at edge N yields rd_data with rd_data_valid in cycle N+1.
    always_comb begin
        capturing = (state == EMPTY) || (state == FILL);
        wr_en     = in_valid && capturing && !clear;
        last_byte = wr_en && (byte_count == LAST_IDX);
        busy_fall = rd_busy_q && !rd_busy;
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[byte_count[ADDR_W-1:0]] <= in_data;
        end
    end

    // Read happens before the same-edge write lands, so a colliding read sees old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data       <= 8'h00;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            rd_busy_q    <= 1'b0;
            sector_ready <= 1'b0;
            byte_count   <= '0;
            checksum     <= 16'h0000;
            short_sector <= 1'b0;
            error_flag   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rd_busy_q <= rd_busy;
            if (clear) begin
                state        <= EMPTY;
                sector_ready <= 1'b0;
                byte_count   <= '0;
                checksum     <= 16'h0000;
                short_sector <= 1'b0;
                error_flag   <= 1'b0;
                overrun      <= 1'b0;
            end else begin
                if (wr_en) begin
                    byte_count <= byte_count + 1'b1;
                    checksum   <= checksum + {8'h00, in_data};
                end
                case (state)
                    EMPTY: begin
                        if (rd_error) begin
                            error_flag <= 1'b1;
                            state      <= ERR;
                        end else if (in_valid) begin
                            state <= FILL;
                        end
                    end
                    FILL: begin
                        // A completing byte wins over a coincident busy fall or error.
                        if (last_byte) begin
                            state        <= READY;
                            sector_ready <= 1'b1;
                        end else if (rd_error) begin
                            error_flag <= 1'b1;
                            state      <= ERR;
                        end else if (busy_fall) begin
                            short_sector <= 1'b1;
                            state        <= ERR;
                        end
                    end
                    READY: begin
                        if (in_valid) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Randomized bench for sd_sector_buffer: status outputs compared each cycle against a
// byte-queue reference model; read data flows through an expected queue to a monitor.
module tb_sd_sector_buffer;

    localparam int SB = 512;
    localparam int AW = 9;
    localparam int ST_EMPTY = 0;
    localparam int ST_FILL  = 1;
    localparam int ST_READY = 2;
    localparam int ST_ERR   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          rd_busy;
    logic          rd_error;
    logic          clear;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          rd_data_valid;
    logic          sector_ready;
    logic [AW:0]   byte_count;
    logic [15:0]   checksum;
    logic          short_sector;
    logic          error_flag;
    logic          overrun;
    logic [1:0]    state_dbg;

    sd_sector_buffer #(.SECTOR_BYTES(SB), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .rd_busy(rd_busy), .rd_error(rd_error), .clear(clear), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .sector_ready(sector_ready), .byte_count(byte_count), .checksum(checksum),
        .short_sector(short_sector), .error_flag(error_flag), .overrun(overrun),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] model_mem [SB];
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    bit m_short, m_err, m_over, m_halted, m_prev_busy;
    logic busy_lvl;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic int model_sum();
        int s = 0;
        foreach (cap_q[i]) s += cap_q[i];
        return s % 65536;
    endfunction

    function automatic int model_state();
        if (m_halted) return ST_ERR;
        if (cap_q.size() == SB) return ST_READY;
        if (cap_q.size() == 0) return ST_EMPTY;
        return ST_FILL;
    endfunction

    task automatic model_reset();
        cap_q.delete();
        m_short = 0; m_err = 0; m_over = 0; m_halted = 0; m_prev_busy = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic busy,
                              input logic err, input logic clr, input logic ren,
                              input logic [AW-1:0] raddr);
        int pre;
        if (ren) exp_q.push_back(model_mem[raddr]);
        pre = cap_q.size();
        if (clr) begin
            cap_q.delete();
            m_short = 0; m_err = 0; m_over = 0; m_halted = 0;
        end else if (!m_halted && pre < SB) begin
            if (v) begin
                model_mem[pre] = d;
                cap_q.push_back(d);
            end
            if (cap_q.size() == SB) begin
                // sector complete: nothing else matters this cycle
            end else if (err) begin
                m_err = 1; m_halted = 1;
            end else if (pre > 0 && m_prev_busy && !busy) begin
                m_short = 1; m_halted = 1;
            end
        end else if (!m_halted && v) begin
            m_over = 1;
        end
        m_prev_busy = busy;
    endtask

    // ---------------- checking ----------------
    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        compare("byte_count", 32'(byte_count), 32'(cap_q.size()));
        compare("checksum", 32'(checksum), 32'(model_sum()));
        compare("sector_ready", 32'(sector_ready), 32'(cap_q.size() == SB && !m_halted));
        compare("short_sector", 32'(short_sector), 32'(m_short));
        compare("error_flag", 32'(error_flag), 32'(m_err));
        compare("overrun", 32'(overrun), 32'(m_over));
        compare("state", 32'(state_dbg), 32'(model_state()));
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_data_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got valid data 0x%0h expected no read at %0t", rd_data, $time);
            end else begin
                compare("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks (called at negedge) ----------------
    task automatic drive(input logic v, input logic [7:0] d, input logic err = 1'b0,
                         input logic clr = 1'b0, input logic ren = 1'b0,
                         input logic [AW-1:0] raddr = '0);
        in_valid = v; in_data = d; rd_error = err; clear = clr;
        rd_en = ren; rd_addr = raddr; rd_busy = busy_lvl;
        model_edge(v, d, busy_lvl, err, clr, ren, raddr);
        @(negedge clk);
        in_valid = 1'b0; rd_error = 1'b0; clear = 1'b0; rd_en = 1'b0;
        check_status();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic send_bytes(input int n, input int mode, input logic [7:0] fixed);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = (mode == 0) ? 8'(i) : (mode == 1) ? fixed : 8'($urandom_range(0, 255));
            drive(1'b1, b);
            idle($urandom_range(0, 3));
        end
    endtask

    task automatic read(input int addr);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, AW'(addr));
    endtask

    task automatic do_clear();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; rd_busy = 1'b0;
        rd_error = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
        busy_lvl = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare("reset_rd_data", 32'(rd_data), 32'h0);
        compare("reset_rd_valid", 32'(rd_data_valid), 32'h0);
        check_status();
        rst_n = 1'b1;

        // Full sector of i[7:0] with random gaps, then reads
        busy_lvl = 1'b1;
        idle(1);
        send_bytes(SB, 0, 8'h00);
        compare("t1_count", 32'(byte_count), 32'd512);
        compare("t1_checksum", 32'(checksum), 32'hFF00);
        read(0); read(255); read(511);
        idle(1);
        busy_lvl = 1'b0;
        idle(2);

        // Overrun after full sector, then clear
        for (int i = 0; i < 3; i++) drive(1'b1, 8'($urandom_range(1, 255)));
        compare("t3_count", 32'(byte_count), 32'd512);
        read(0);
        idle(1);
        do_clear();
        idle(1);

        // Short sector: 100 bytes of 0xA5 then busy falls
        busy_lvl = 1'b1;
        idle(1);
        send_bytes(100, 1, 8'hA5);
        busy_lvl = 1'b0;
        idle(1);
        compare("t2_checksum", 32'(checksum), 32'h4074);
        compare("t2_count", 32'(byte_count), 32'd100);
        send_bytes(4, 2, 8'h00);
        do_clear();

        // Reader error after 10 bytes, separate and coincident with a byte
        busy_lvl = 1'b1;
        idle(1);
        send_bytes(10, 2, 8'h00);
        drive(1'b0, 8'h00, 1'b1);
        send_bytes(5, 2, 8'h00);
        compare("t4_count", 32'(byte_count), 32'd10);
        do_clear();
        send_bytes(10, 2, 8'h00);
        drive(1'b1, 8'h3C, 1'b1);
        send_bytes(3, 2, 8'h00);
        compare("t4b_count", 32'(byte_count), 32'd11);
        do_clear();

        // 512th byte coincident with busy fall; same-address write/read collision
        idle(1);
        send_bytes(40, 2, 8'h00);
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, AW'(40));
        send_bytes(SB - 42, 2, 8'h00);
        busy_lvl = 1'b0;
        drive(1'b1, 8'($urandom_range(0, 255)));
        compare("t5_short", 32'(short_sector), 32'h0);
        read(40); read(SB - 1);
        do_clear();
        busy_lvl = 1'b1;
        send_bytes(7, 2, 8'h00);
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        compare("t5_clear_drop", 32'(byte_count), 32'd0);
        idle(1);

        // Asynchronous reset at byte 300, then a fresh sector
        send_bytes(300, 2, 8'h00);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare("async_rst_count", 32'(byte_count), 32'h0);
        compare("async_rst_checksum", 32'(checksum), 32'h0);
        compare("async_rst_state", 32'(state_dbg), 32'(ST_EMPTY));
        compare("async_rst_rd_valid", 32'(rd_data_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_status();
        send_bytes(SB, 2, 8'h00);
        compare("t6_count", 32'(byte_count), 32'd512);

        // Random back-to-back reads across the sector
        for (int i = 0; i < 24; i++) read($urandom_range(0, SB - 1));
        idle(3);
        compare("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
